// File: rtl/vector_multiply_arbiter.sv
// vector_multiply_arbiter: round-robin sequencer sharing one vector multiplier among requesters
module vector_multiply_arbiter #(
   parameter int C_OP_WIDTH = 16,
   parameter int C_NUM_OPERANDS = 2,
   parameter int C_NUM_REQ = 4,
   parameter int C_TIMEOUT = 64,
   localparam int C_DATAIN_WIDTH = C_OP_WIDTH*C_NUM_OPERANDS,
   localparam int C_DOUT_WIDTH = C_OP_WIDTH*(C_NUM_OPERANDS/2),
   localparam int C_ID_WIDTH = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [C_NUM_REQ*C_DATAIN_WIDTH-1:0] req_datain,
   input  logic [C_NUM_REQ-1:0]                req_valid,
   output logic [C_NUM_REQ-1:0]                req_ready,
   output logic [C_DATAIN_WIDTH-1:0]           mult_datain,
   output logic                                mult_datain_valid,
   output logic                                mult_dout_ready,
   input  logic [C_DOUT_WIDTH-1:0]             mult_dout,
   input  logic                                mult_dout_valid,
   output logic [C_DOUT_WIDTH-1:0]             dout,
   output logic [C_ID_WIDTH-1:0]               dout_id,
   output logic                                dout_err,
   output logic [C_NUM_REQ-1:0]                dout_valid,
   input  logic [C_NUM_REQ-1:0]                dout_ready
);
   localparam int CW = (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;
   state_t state;
   logic [C_ID_WIDTH-1:0] rr_ptr, grant_id, win;
   logic [C_ID_WIDTH:0] scan;
   logic any;
   logic [CW-1:0] cnt;
   // rotating-priority search from rr_ptr; the smallest offset with a valid request wins
   always_comb begin
      win = '0;
      any = 1'b0;
      scan = '0;
      for (int k = C_NUM_REQ-1; k >= 0; k--) begin
         scan = {1'b0, rr_ptr} + (C_ID_WIDTH+1)'(k);
         scan = (scan >= (C_ID_WIDTH+1)'(C_NUM_REQ)) ? scan - (C_ID_WIDTH+1)'(C_NUM_REQ) : scan;
         if (req_valid[scan[C_ID_WIDTH-1:0]]) begin
            win = scan[C_ID_WIDTH-1:0];
            any = 1'b1;
         end
      end
   end
   assign req_ready = (!rst && state == IDLE && any) ? (C_NUM_REQ'(1) << win) : '0;
   assign dout_id = grant_id;
   // single-transaction sequencer: accept, issue, wait with watchdog, deliver to owner
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rr_ptr <= '0;
         grant_id <= '0;
         cnt <= '0;
         mult_datain <= '0;
         mult_datain_valid <= 1'b0;
         mult_dout_ready <= 1'b0;
         dout <= '0;
         dout_err <= 1'b0;
         dout_valid <= '0;
      end else begin
         case (state)
            IDLE: if (any) begin
               mult_datain <= req_datain[win*C_DATAIN_WIDTH +: C_DATAIN_WIDTH];
               grant_id <= win;
               rr_ptr <= (win == C_ID_WIDTH'(C_NUM_REQ-1)) ? '0 : win + 1'b1;
               mult_datain_valid <= 1'b1;
               mult_dout_ready <= 1'b1;
               state <= ISSUE;
            end
            ISSUE: begin
               mult_datain_valid <= 1'b0;
               cnt <= '0;
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (mult_dout_valid || cnt == CW'(C_TIMEOUT-1)) begin
                  dout <= mult_dout_valid ? mult_dout : '0;
                  dout_err <= !mult_dout_valid;
                  dout_valid <= C_NUM_REQ'(1) << grant_id;
                  mult_dout_ready <= 1'b0;
                  state <= DELIVER;
               end
            end
            DELIVER: if (dout_ready[grant_id]) begin
               dout_valid <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vector_multiply_arbiter.sv
// tb_vector_multiply_arbiter: randomized scoreboard bench with a stand-in multiplier
module tb_vector_multiply_arbiter;
   localparam int N = 4, TO = 8, DW = 32, OW = 16;
   typedef struct {int id; int d; bit err; int cyc; int bp;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N*DW-1:0] req_datain = '0;
   logic [N-1:0] req_valid = '0;
   logic [N-1:0] req_ready, dout_valid;
   logic [N-1:0] dout_ready = '1;
   logic [DW-1:0] mult_datain;
   logic mult_datain_valid, mult_dout_ready, dout_err;
   logic mult_dout_valid = 1'b0;
   logic [OW-1:0] mult_dout = '0;
   logic [OW-1:0] dout;
   logic [1:0] dout_id;
   exp_t q[$];
   exp_t me;
   int n_cmp = 0, n_err = 0, cyc = 0, rr = 0, mlat = 1;
   int last_acc = 0, last_wait = 0, prev_acc = 0, mc = -1;
   logic [DW-1:0] exp_md = '0;
   logic [OW-1:0] mp = '0;
   logic [N*DW-1:0] dtmp;

   vector_multiply_arbiter #(.C_OP_WIDTH(16), .C_NUM_OPERANDS(2), .C_NUM_REQ(N), .C_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_datain(req_datain), .req_valid(req_valid), .req_ready(req_ready),
      .mult_datain(mult_datain), .mult_datain_valid(mult_datain_valid), .mult_dout_ready(mult_dout_ready),
      .mult_dout(mult_dout), .mult_dout_valid(mult_dout_valid), .dout(dout), .dout_id(dout_id),
      .dout_err(dout_err), .dout_valid(dout_valid), .dout_ready(dout_ready));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endfunction

   function automatic logic [N*DW-1:0] rnd();
      logic [N*DW-1:0] r;
      for (int i = 0; i < N; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // stand-in multiplier: answers mlat cycles after an issue (never when mlat is 0)
   initial begin
      forever begin
         @(negedge clk);
         mult_dout_valid = 1'b0;
         if (mc > 0) begin
            mc--;
            if (mc == 0) begin
               mult_dout_valid = 1'b1;
               mult_dout = mp;
               mc = -1;
            end
         end
         if (mult_datain_valid === 1'b1) begin
            chk("mult_datain", mult_datain, exp_md);
            chk("mult_dout_ready_issue", {31'd0, mult_dout_ready}, 1);
            mp = mult_datain[OW-1:0] * mult_datain[DW-1:OW];
            mc = (mlat > 0) ? mlat : -1;
         end
      end
   end

   // one request: model picks the winner, scoreboard gets the expected result
   task automatic txn(input logic [N-1:0] vm, input logic [N*DW-1:0] din, input int lat,
                      input int bp, input bit keep, input bit push);
      int w = -1, waited = 0;
      int eff;
      exp_t e;
      logic [31:0] pa, pb, pr;
      for (int k = N-1; k >= 0; k--) if (vm[(rr + k) % N]) w = (rr + k) % N;
      req_datain = din;
      req_valid = vm;
      mlat = lat;
      #1;
      while (req_ready == '0 && waited < 100) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (req_ready == '0) begin
         chk("accept_wait", {28'd0, req_ready}, N'(1) << w);
         req_valid = '0;
         return;
      end
      chk("req_ready", {28'd0, req_ready}, N'(1) << w);
      last_wait = waited;
      last_acc = cyc;
      eff = (lat > 0 && lat <= TO) ? lat : TO;
      exp_md = din[w*DW +: DW];
      if (push) begin
         pa = 32'(din[w*DW +: OW]);
         pb = 32'(din[w*DW+OW +: OW]);
         pr = pa * pb;
         e.id = w;
         e.err = !(lat > 0 && lat <= TO);
         e.d = e.err ? 0 : int'(pr[15:0]);
         e.cyc = cyc + 2 + eff;
         e.bp = bp;
         q.push_back(e);
      end
      rr = (w + 1) % N;
      @(negedge clk);
      if (!keep) req_valid = '0;
      @(negedge clk);
   endtask

   // monitor: pops and compares whenever a result is presented, applies back-pressure
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && dout_valid != '0) begin
            if (q.size() == 0) chk("unexpected_dout_valid", {28'd0, dout_valid}, 0);
            else begin
               me = q.pop_front();
               chk("dout", {16'd0, dout}, me.d);
               chk("dout_id", {30'd0, dout_id}, me.id);
               chk("dout_err", {31'd0, dout_err}, {31'd0, me.err});
               chk("dout_valid", {28'd0, dout_valid}, N'(1) << me.id);
               chk("latency", cyc, me.cyc);
               chk("mult_dout_ready_deliver", {31'd0, mult_dout_ready}, 0);
               for (int i = 0; i < me.bp; i++) begin
                  dout_ready = N'($urandom) & ~(N'(1) << me.id);
                  @(negedge clk);
                  chk("bp_dout", {16'd0, dout}, me.d);
                  chk("bp_dout_id", {30'd0, dout_id}, me.id);
                  chk("bp_dout_valid", {28'd0, dout_valid}, N'(1) << me.id);
                  chk("bp_req_ready", {28'd0, req_ready}, 0);
               end
               dout_ready = '1;
               @(negedge clk);
               chk("dout_valid_clear", {28'd0, dout_valid}, 0);
            end
         end
      end
   end

   initial begin
      req_valid = '1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_req_ready", {28'd0, req_ready}, 0);
         chk("rst_mult_datain_valid", {31'd0, mult_datain_valid}, 0);
         chk("rst_mult_dout_ready", {31'd0, mult_dout_ready}, 0);
         chk("rst_dout_valid", {28'd0, dout_valid}, 0);
         chk("rst_dout", {16'd0, dout}, 0);
         chk("rst_dout_id", {30'd0, dout_id}, 0);
         chk("rst_dout_err", {31'd0, dout_err}, 0);
         chk("rst_mult_datain", mult_datain, 0);
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         txn('1, rnd(), 1, 0, i < 4, 1);
         if (i == 0) chk("first_grant_wait", last_wait, 0);
         else chk("period", last_acc - prev_acc, 4);
         prev_acc = last_acc;
      end
      txn(4'b0100, rnd(), 1, 0, 0, 1);
      dtmp = rnd();
      dtmp[DW +: DW] = {16'd7, 16'd6};
      txn(4'b0010, dtmp, 1, 0, 0, 1);
      txn(4'b1011, rnd(), 2, 5, 0, 1);
      txn(4'b0110, rnd(), 0, 0, 0, 1);
      txn(4'b1111, rnd(), TO, 0, 0, 1);
      txn(4'b1000, rnd(), 6, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_dout_valid", {28'd0, dout_valid}, 0);
      chk("midrst_mult_datain_valid", {31'd0, mult_datain_valid}, 0);
      chk("midrst_mult_dout_ready", {31'd0, mult_dout_ready}, 0);
      chk("midrst_mult_datain", mult_datain, 0);
      rst = 1'b0;
      rr = 0;
      repeat (8) @(negedge clk);
      txn('1, rnd(), 1, 0, 0, 1);
      for (int i = 0; i < 25; i++)
         txn(N'($urandom_range(1, 15)), rnd(), $urandom_range(0, TO), $urandom_range(0, 3), 0, 1);
      for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
      chk("drain", q.size(), 0);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
